lane_demux8: RTL

LANE_DEMUX8 -- requirements
Module: lane_demux8

---
 rtl/lane_demux8.sv | 104 ++++++++++
 1 files changed

// File: rtl/lane_demux8.sv
// Serial-to-parallel lane demultiplexer: collects up to eight N-bit words into
// lane registers and presents them as one vector, flushing early on InLast.
module lane_demux8 #(
  parameter int N = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         InValid,
  input  logic [N-1:0] InData,
  input  logic         InLast,
  output logic         InReady,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] Out0,
  output logic [N-1:0] Out1,
  output logic [N-1:0] Out2,
  output logic [N-1:0] Out3,
  output logic [N-1:0] Out4,
  output logic [N-1:0] Out5,
  output logic [N-1:0] Out6,
  output logic [N-1:0] Out7,
  output logic [7:0]   OutMask,
  output logic         DbgHold
);

  // Handshake: a word moves on InValid&&InReady, a vector on OutValid&&OutReady.
  // Both ready/valid outputs decode only the state register, never the inputs.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [2:0]   idx;
  logic [N-1:0] lane [8];
  logic         in_xfer;
  logic         out_xfer;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    OutValid  = 1'b0;
    in_xfer   = 1'b0;
    out_xfer  = 1'b0;
    case (state)
      FILL: begin
        InReady = 1'b1;
        in_xfer = InValid;
        if (InValid && (InLast || idx == 3'd7)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        OutValid = 1'b1;
        out_xfer = OutReady;
        if (OutReady) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Lanes not reached by a short vector keep their cleared value of zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      idx     <= 3'd0;
      OutMask <= 8'd0;
      for (int k = 0; k < 8; k++) begin
        lane[k] <= '0;
      end
    end else if (out_xfer) begin
      idx     <= 3'd0;
      OutMask <= 8'd0;
      for (int k = 0; k < 8; k++) begin
        lane[k] <= '0;
      end
    end else if (in_xfer) begin
      lane[idx]    <= InData;
      OutMask[idx] <= 1'b1;
      idx          <= idx + 3'd1;
    end
  end

  assign Out0    = lane[0];
  assign Out1    = lane[1];
  assign Out2    = lane[2];
  assign Out3    = lane[3];
  assign Out4    = lane[4];
  assign Out5    = lane[5];
  assign Out6    = lane[6];
  assign Out7    = lane[7];
  assign DbgHold = (state == HOLD);

endmodule
